// File: rtl/multdiv_pkg.sv
// Shared encodings, default exception codes and a sizing helper for the
// multdiv issue controller.
package multdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } md_state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int EXC_MULT_DEF    = 4;
  localparam int EXC_DIV_DEF     = 5;
  localparam int RSTATUS_REG_DEF = 30;

  function automatic int cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/md_wait_counter.sv
// Saturating WAIT-cycle counter: cleared while the start pulse goes out,
// counts each waiting cycle and stops at TIMEOUT.
module md_wait_counter
  import multdiv_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic cnt_nz,
  output logic cnt_timeout
);

  localparam int W = cnt_width(TIMEOUT);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

  logic [W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LIMIT)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign cnt_nz      = (cnt != '0);
  assign cnt_timeout = (cnt == LIMIT);

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Issue controller: latches one MULT/DIV request, pulses the multdiv start,
// stalls the pipeline until the result is ready, then issues one writeback.
module multdiv_issue_ctrl
  import multdiv_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_W       = 5,
  parameter int RSTATUS_REG = RSTATUS_REG_DEF,
  parameter int EXC_MULT    = EXC_MULT_DEF,
  parameter int EXC_DIV     = EXC_DIV_DEF,
  parameter int TIMEOUT     = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [REG_W-1:0]  req_rd,
  output logic              req_ready,
  input  logic              kill,
  output logic              stall,
  output logic [REG_W-1:0]  busy_rd,
  output logic              busy_valid,
  output logic [DATA_W-1:0] md_operandA,
  output logic [DATA_W-1:0] md_operandB,
  output logic              md_ctrl_MULT,
  output logic              md_ctrl_DIV,
  input  logic [DATA_W-1:0] md_result,
  input  logic              md_exception,
  input  logic              md_resultRDY,
  output logic              wb_valid,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data
);

  localparam logic [REG_W-1:0]  RSTATUS_ADDR  = REG_W'(RSTATUS_REG);
  localparam logic [DATA_W-1:0] EXC_MULT_CODE = DATA_W'(EXC_MULT);
  localparam logic [DATA_W-1:0] EXC_DIV_CODE  = DATA_W'(EXC_DIV);

  md_state_t state;
  logic      op;
  logic      wb_pend;
  logic      cnt_nz;
  logic      cnt_timeout;
  logic      accept;
  logic      rdy_ok;
  logic      exc;

  md_wait_counter #(.TIMEOUT(TIMEOUT)) u_wait_counter (
    .clock       (clock),
    .reset       (reset),
    .clear       (state == ST_START),
    .enable      (state == ST_WAIT),
    .cnt_nz      (cnt_nz),
    .cnt_timeout (cnt_timeout)
  );

  assign accept = (state == ST_IDLE) && req_valid && req_ready && !kill;
  // RDY in the first WAIT cycle may still belong to the previous operation.
  assign rdy_ok = (state == ST_WAIT) && cnt_nz && md_resultRDY;
  assign exc    = rdy_ok ? md_exception : 1'b1;

  assign md_ctrl_MULT = (state == ST_START) && !kill && (op == OP_MULT);
  assign md_ctrl_DIV  = (state == ST_START) && !kill && (op == OP_DIV);
  assign wb_valid     = wb_pend && !kill;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      op          <= OP_MULT;
      busy_rd     <= '0;
      md_operandA <= '0;
      md_operandB <= '0;
      req_ready   <= 1'b0;
      stall       <= 1'b0;
      busy_valid  <= 1'b0;
      wb_pend     <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
    end else begin
      wb_pend <= 1'b0;
      if ((state != ST_IDLE) && kill) begin
        state      <= ST_IDLE;
        req_ready  <= 1'b1;
        stall      <= 1'b0;
        busy_valid <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            req_ready  <= !accept;
            stall      <= accept;
            busy_valid <= accept;
            if (accept) begin
              state       <= ST_START;
              op          <= req_op;
              busy_rd     <= req_rd;
              md_operandA <= req_a;
              md_operandB <= req_b;
            end
          end
          ST_START: state <= ST_WAIT;
          ST_WAIT: begin
            // A timeout writes the exception code just like a reported exception.
            if (rdy_ok || cnt_timeout) begin
              state   <= ST_WB;
              wb_pend <= exc || (busy_rd != '0);
              wb_rd   <= exc ? RSTATUS_ADDR : busy_rd;
              wb_data <= exc ? ((op == OP_DIV) ? EXC_DIV_CODE : EXC_MULT_CODE) : md_result;
            end
          end
          ST_WB: begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            stall      <= 1'b0;
            busy_valid <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Directed bench for multdiv_issue_ctrl: scripted scenarios with literal
// expectations plus a cycle-level reference model checked on every falling edge.
module tb_multdiv_issue_ctrl;

  localparam int TMO = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_op = 1'b0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [4:0]  req_rd = '0;
  logic        kill = 1'b0;
  logic [31:0] md_result = '0;
  logic        md_exception = 1'b0;
  logic        md_resultRDY = 1'b0;

  logic        req_ready, stall, busy_valid, md_ctrl_MULT, md_ctrl_DIV, wb_valid;
  logic [4:0]  busy_rd, wb_rd;
  logic [31:0] md_operandA, md_operandB, wb_data;

  multdiv_issue_ctrl #(.DATA_W(32), .REG_W(5), .TIMEOUT(TMO)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_rd       (req_rd),
    .req_ready    (req_ready),
    .kill         (kill),
    .stall        (stall),
    .busy_rd      (busy_rd),
    .busy_valid   (busy_valid),
    .md_operandA  (md_operandA),
    .md_operandB  (md_operandB),
    .md_ctrl_MULT (md_ctrl_MULT),
    .md_ctrl_DIV  (md_ctrl_DIV),
    .md_result    (md_result),
    .md_exception (md_exception),
    .md_resultRDY (md_resultRDY),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_mult = 0;
  int n_div = 0;
  int n_wb = 0;

  // Reference model: request lifetime tracked as an age in cycles since accept
  bit          m_init = 0;
  bit          m_ready_ok = 0;
  bit          m_busy = 0;
  bit          m_in_wb = 0;
  bit          m_wb_write = 0;
  int          m_age = 0;
  bit          m_op = 0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic [4:0]  m_wb_rd = '0;
  logic [31:0] m_wb_data = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic modelFinish(input bit exc, input logic [31:0] res);
    m_in_wb    = 1;
    m_wb_write = exc || (m_rd != 5'd0);
    m_wb_rd    = exc ? 5'd30 : m_rd;
    m_wb_data  = exc ? (m_op ? 32'd5 : 32'd4) : res;
  endtask

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (md_ctrl_MULT) n_mult++;
    if (md_ctrl_DIV) n_div++;
    if (wb_valid) n_wb++;
  end

  // Compare against the model, then advance it with this cycle's inputs
  always @(negedge clock) begin
    if (m_init) begin
      checkOutput("m_req_ready", req_ready, m_ready_ok && !m_busy);
      checkOutput("m_stall", stall, m_busy);
      checkOutput("m_busy_valid", busy_valid, m_busy);
      checkOutput("m_ctrl_MULT", md_ctrl_MULT, m_busy && m_age == 1 && !kill && !m_op);
      checkOutput("m_ctrl_DIV", md_ctrl_DIV, m_busy && m_age == 1 && !kill && m_op);
      checkOutput("m_wb_valid", wb_valid, m_in_wb && m_wb_write && !kill);
      if (m_busy) begin
        checkOutput("m_busy_rd", busy_rd, m_rd);
        checkOutput("m_operandA", md_operandA, m_a);
        checkOutput("m_operandB", md_operandB, m_b);
      end
      if (m_in_wb && m_wb_write && !kill) begin
        checkOutput("m_wb_rd", wb_rd, m_wb_rd);
        checkOutput("m_wb_data", wb_data, m_wb_data);
      end
    end
    if (reset) begin
      m_init = 1; m_ready_ok = 0; m_busy = 0; m_in_wb = 0; m_wb_write = 0;
    end else begin
      if (m_busy) begin
        if (kill || m_in_wb) begin
          m_busy = 0; m_in_wb = 0; m_wb_write = 0;
        end else if (m_age >= 3 && md_resultRDY) begin
          modelFinish(md_exception, md_result);
        end else if (m_age - 2 == TMO) begin
          modelFinish(1'b1, 32'd0);
        end else begin
          m_age++;
        end
      end else if (req_valid && m_ready_ok && !kill) begin
        m_busy = 1; m_age = 1; m_op = req_op; m_rd = req_rd; m_a = req_a; m_b = req_b;
      end
      m_ready_ok = 1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Waits (bounded) for req_ready, presents one request, returns in the START cycle
  task automatic applyStimulus(input bit op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd);
    int waited = 0;
    while (!req_ready && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput("ready_before_issue", req_ready, 1);
    req_valid = 1; req_op = op; req_a = a; req_b = b; req_rd = rd;
    tick();
    req_valid = 0;
  endtask

  // Raises RDY for one cycle; returns in the following cycle
  task automatic pulseRdy(input logic [31:0] res, input bit exc);
    md_resultRDY = 1; md_result = res; md_exception = exc;
    tick();
    md_resultRDY = 0; md_exception = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    n_fail++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base_mult, base_div, base_wb, p_cyc, waited;

    repeat (3) tick();
    checkOutput("reset_req_ready", req_ready, 0);
    checkOutput("reset_stall", stall, 0);
    checkOutput("reset_wb_valid", wb_valid, 0);
    reset = 0;
    tick();
    checkOutput("ready_after_reset", req_ready, 1);

    $display("[TB] MULT 6*7 -> r3");
    base_mult = n_mult; base_wb = n_wb;
    applyStimulus(1'b0, 32'd6, 32'd7, 5'd3);
    checkOutput("t1_pulse", md_ctrl_MULT, 1);
    checkOutput("t1_operandA", md_operandA, 6);
    checkOutput("t1_stall", stall, 1);
    repeat (5) tick();
    pulseRdy(32'd42, 1'b0);
    checkOutput("t1_wb_valid", wb_valid, 1);
    checkOutput("t1_wb_rd", wb_rd, 3);
    checkOutput("t1_wb_data", wb_data, 42);
    checkOutput("t1_stall_wb", stall, 1);
    tick();
    checkOutput("t1_ready_again", req_ready, 1);
    checkOutput("t1_pulse_count", n_mult - base_mult, 1);
    checkOutput("t1_wb_count", n_wb - base_wb, 1);

    $display("[TB] DIV 10/0 with exception");
    base_div = n_div;
    applyStimulus(1'b1, 32'd10, 32'd0, 5'd4);
    repeat (3) tick();
    pulseRdy(32'hDEAD, 1'b1);
    checkOutput("t2_wb_valid", wb_valid, 1);
    checkOutput("t2_wb_rd", wb_rd, 30);
    checkOutput("t2_wb_data", wb_data, 5);
    tick();
    checkOutput("t2_div_pulses", n_div - base_div, 1);

    $display("[TB] stale RDY ignored");
    base_wb = n_wb;
    md_resultRDY = 1; md_result = 32'd111;
    applyStimulus(1'b0, 32'd2, 32'd5, 5'd6);
    tick();
    tick();
    md_resultRDY = 0;
    checkOutput("t3_no_early_wb", n_wb - base_wb, 0);
    tick();
    pulseRdy(32'd10, 1'b0);
    checkOutput("t3_wb_rd", wb_rd, 6);
    checkOutput("t3_wb_data", wb_data, 10);
    tick();

    $display("[TB] timeouts");
    for (int k = 0; k < 2; k++) begin
      applyStimulus(k[0], 32'd9, 32'd9, 5'd7);
      p_cyc = cyc;
      waited = 0;
      while (!wb_valid && waited < 40) begin
        tick();
        waited++;
      end
      checkOutput("tmo_wb_seen", wb_valid, 1);
      // START, then WAIT with counts 0..8, then WB: 10 edges after START
      checkOutput("tmo_latency", cyc - p_cyc, 10);
      checkOutput("tmo_wb_rd", wb_rd, 30);
      checkOutput("tmo_wb_data", wb_data, (k == 1) ? 32'd5 : 32'd4);
      tick();
      checkOutput("tmo_ready", req_ready, 1);
    end

    $display("[TB] kill in START");
    base_div = n_div;
    applyStimulus(1'b1, 32'd8, 32'd2, 5'd9);
    kill = 1;
    #1;
    checkOutput("kill_start_no_pulse", md_ctrl_DIV, 0);
    tick();
    kill = 0;
    checkOutput("kill_start_ready", req_ready, 1);
    checkOutput("kill_start_pulses", n_div - base_div, 0);

    $display("[TB] kill in WAIT, then late RDY");
    base_wb = n_wb;
    applyStimulus(1'b0, 32'd4, 32'd4, 5'd8);
    tick();
    tick();
    kill = 1;
    tick();
    kill = 0;
    checkOutput("kill_wait_ready", req_ready, 1);
    pulseRdy(32'd16, 1'b0);
    checkOutput("kill_wait_no_wb", wb_valid, 0);
    tick();
    checkOutput("kill_wait_wb_count", n_wb - base_wb, 0);
    applyStimulus(1'b0, 32'd3, 32'd3, 5'd5);
    repeat (2) tick();
    pulseRdy(32'd9, 1'b0);
    checkOutput("after_kill_wb_rd", wb_rd, 5);
    checkOutput("after_kill_wb_data", wb_data, 9);
    tick();

    $display("[TB] kill in WB");
    base_wb = n_wb;
    applyStimulus(1'b0, 32'd5, 32'd5, 5'd10);
    repeat (2) tick();
    pulseRdy(32'd25, 1'b0);
    kill = 1;
    #1;
    checkOutput("kill_wb_suppressed", wb_valid, 0);
    tick();
    kill = 0;
    checkOutput("kill_wb_ready", req_ready, 1);
    checkOutput("kill_wb_count", n_wb - base_wb, 0);

    $display("[TB] MULT to r0");
    applyStimulus(1'b0, 32'd7, 32'd7, 5'd0);
    repeat (2) tick();
    pulseRdy(32'd49, 1'b0);
    checkOutput("r0_no_wb", wb_valid, 0);
    tick();
    checkOutput("r0_ready", req_ready, 1);

    $display("[TB] back-to-back requests");
    base_mult = n_mult; base_div = n_div; base_wb = n_wb;
    applyStimulus(1'b0, 32'd2, 32'd8, 5'd11);
    req_valid = 1; req_op = 1; req_a = 32'd20; req_b = 32'd4; req_rd = 5'd12;
    checkOutput("b2b_held_not_ready", req_ready, 0);
    repeat (2) tick();
    pulseRdy(32'd16, 1'b0);
    checkOutput("b2b_first_wb_rd", wb_rd, 11);
    checkOutput("b2b_first_wb_data", wb_data, 16);
    checkOutput("b2b_not_ready_in_wb", req_ready, 0);
    tick();
    checkOutput("b2b_ready", req_ready, 1);
    tick();
    req_valid = 0;
    checkOutput("b2b_second_pulse", md_ctrl_DIV, 1);
    repeat (2) tick();
    pulseRdy(32'd5, 1'b0);
    checkOutput("b2b_second_wb_rd", wb_rd, 12);
    checkOutput("b2b_second_wb_data", wb_data, 5);
    tick();
    checkOutput("b2b_mult_pulses", n_mult - base_mult, 1);
    checkOutput("b2b_div_pulses", n_div - base_div, 1);
    checkOutput("b2b_wb_count", n_wb - base_wb, 2);

    $display("[TB] reset mid-operation");
    base_wb = n_wb;
    applyStimulus(1'b0, 32'd1, 32'd1, 5'd13);
    tick();
    reset = 1;
    tick();
    reset = 0;
    checkOutput("midrst_stall", stall, 0);
    checkOutput("midrst_ready", req_ready, 0);
    pulseRdy(32'd77, 1'b0);
    checkOutput("midrst_no_wb", wb_valid, 0);
    checkOutput("midrst_ready_back", req_ready, 1);
    tick();
    checkOutput("midrst_wb_count", n_wb - base_wb, 0);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
